// File: rtl/aes_ctr_encrypt_stream.sv
// AES-CTR encryption sequencer: drives an external AES core with successive
// counter blocks and XORs each returned keystream block with host plaintext.
module aes_ctr_encrypt_stream #(
  parameter int unsigned CTR_WIDTH = 32,
  parameter int unsigned LEN_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [127:0]         nonce,
  input  logic [LEN_WIDTH-1:0] num_blocks,
  input  logic                 abort,
  input  logic                 pt_valid,
  output logic                 pt_ready,
  input  logic [127:0]         pt_data,
  output logic                 ct_valid,
  input  logic                 ct_ready,
  output logic [127:0]         ct_data,
  output logic                 ct_last,
  output logic                 core_start,
  output logic [127:0]         core_block,
  input  logic                 core_done,
  input  logic [127:0]         core_result,
  output logic                 busy,
  output logic                 done,
  output logic                 ctr_wrap
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GEN,
    S_WAIT_CORE,
    S_WAIT_PT,
    S_OUT
  } state_t;

  state_t               r_state;
  logic [127:0]         r_ctr;
  logic [127:0]         r_keystream;
  logic [LEN_WIDTH-1:0] r_remaining;
  logic                 r_pt_ready;
  logic                 r_ct_valid;
  logic                 r_ct_last;
  logic [127:0]         r_ct_data;
  logic                 r_core_start;
  logic [127:0]         r_core_block;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_ctr_wrap;

  logic [CTR_WIDTH-1:0] w_ctr_lo_inc;
  logic                 w_ctr_lo_max;
  logic                 w_is_last;
  logic [LEN_WIDTH-1:0] w_remaining_dec;

  // Only the low CTR_WIDTH bits of the counter block step; the rest stay as latched.
  assign w_ctr_lo_inc    = r_ctr[CTR_WIDTH-1:0] + CTR_WIDTH'(1);
  assign w_ctr_lo_max    = &r_ctr[CTR_WIDTH-1:0];
  assign w_is_last       = (r_remaining == LEN_WIDTH'(1));
  assign w_remaining_dec = r_remaining - LEN_WIDTH'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_ctr        <= '0;
      r_keystream  <= '0;
      r_remaining  <= '0;
      r_pt_ready   <= 1'b0;
      r_ct_valid   <= 1'b0;
      r_ct_last    <= 1'b0;
      r_ct_data    <= '0;
      r_core_start <= 1'b0;
      r_core_block <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_ctr_wrap   <= 1'b0;
    end else if (abort && (r_state != S_IDLE)) begin
      // ct_data and ctr_wrap deliberately keep their values across an abort.
      r_state      <= S_IDLE;
      r_pt_ready   <= 1'b0;
      r_ct_valid   <= 1'b0;
      r_ct_last    <= 1'b0;
      r_core_start <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_ctr       <= nonce;
            r_remaining <= num_blocks;
            r_ctr_wrap  <= 1'b0;
            if (num_blocks == '0) begin
              r_done <= 1'b1;
            end else begin
              r_state      <= S_GEN;
              r_core_start <= 1'b1;
              r_core_block <= nonce;
              r_busy       <= 1'b1;
            end
          end
        end

        S_GEN: begin
          r_core_start <= 1'b0;
          r_state      <= S_WAIT_CORE;
        end

        S_WAIT_CORE: begin
          if (core_done) begin
            r_keystream            <= core_result;
            r_ctr[CTR_WIDTH-1:0]   <= w_ctr_lo_inc;
            if (w_ctr_lo_max) begin
              r_ctr_wrap <= 1'b1;
            end
            r_pt_ready <= 1'b1;
            r_state    <= S_WAIT_PT;
          end
        end

        S_WAIT_PT: begin
          if (pt_valid && r_pt_ready) begin
            r_ct_data   <= r_keystream ^ pt_data;
            r_ct_valid  <= 1'b1;
            r_ct_last   <= w_is_last;
            r_remaining <= w_remaining_dec;
            r_pt_ready  <= 1'b0;
            r_state     <= S_OUT;
          end
        end

        S_OUT: begin
          if (r_ct_valid && ct_ready) begin
            r_ct_valid <= 1'b0;
            r_ct_last  <= 1'b0;
            if (r_remaining == '0) begin
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
            end else begin
              r_core_start <= 1'b1;
              r_core_block <= r_ctr;
              r_state      <= S_GEN;
            end
          end
        end

        default: begin
          r_state      <= S_IDLE;
          r_pt_ready   <= 1'b0;
          r_ct_valid   <= 1'b0;
          r_ct_last    <= 1'b0;
          r_core_start <= 1'b0;
          r_busy       <= 1'b0;
        end
      endcase
    end
  end

  assign pt_ready   = r_pt_ready;
  assign ct_valid   = r_ct_valid;
  assign ct_data    = r_ct_data;
  assign ct_last    = r_ct_last;
  assign core_start = r_core_start;
  assign core_block = r_core_block;
  assign busy       = r_busy;
  assign done       = r_done;
  assign ctr_wrap   = r_ctr_wrap;

endmodule

// File: tb/tb_aes_ctr_encrypt_stream.sv
// Bench for aes_ctr_encrypt_stream: behavioural AES-128 core with 10-cycle
// latency, scoreboarded ciphertext, per-scenario check tasks.
module tb_aes_ctr_encrypt_stream;

  localparam logic [127:0] KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  logic         clk = 1'b0;
  logic         reset, start, abort, pt_valid, ct_ready;
  logic [127:0] nonce, pt_data;
  logic [15:0]  num_blocks;
  logic         pt_ready, ct_valid, ct_last, core_start, busy, done, ctr_wrap;
  logic [127:0] ct_data, core_block;
  logic         core_done = 1'b0;
  logic [127:0] core_result = '0;

  int n_pass = 0;
  int n_total = 0;

  logic [127:0] q_core_seen[$];
  logic [127:0] q_exp_ct[$];
  logic         q_exp_last[$];

  aes_ctr_encrypt_stream #(.CTR_WIDTH(32), .LEN_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .start(start), .nonce(nonce), .num_blocks(num_blocks),
    .abort(abort), .pt_valid(pt_valid), .pt_ready(pt_ready), .pt_data(pt_data),
    .ct_valid(ct_valid), .ct_ready(ct_ready), .ct_data(ct_data), .ct_last(ct_last),
    .core_start(core_start), .core_block(core_block), .core_done(core_done),
    .core_result(core_result), .busy(busy), .done(done), .ctr_wrap(ctr_wrap)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural AES-128 ----------------
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00; x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] sb(input logic [7:0] x);
    logic [7:0] inv, sq;
    inv = 8'h01; sq = x;
    for (int k = 1; k < 8; k++) begin
      sq  = gm(sq, sq);
      inv = gm(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] aes128(input logic [127:0] key, input logic [127:0] pt);
    logic [31:0]  w[44];
    logic [31:0]  t;
    logic [7:0]   rc, a0, a1, a2, a3;
    logic [7:0]   s[16];
    logic [7:0]   n[16];
    logic [127:0] res;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sb(t[23:16]), sb(t[15:8]), sb(t[7:0]), sb(t[31:24])} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) n[i] = sb(s[(i%4) + 4*(((i/4) + (i%4)) % 4)]);
      for (int c = 0; c < 4; c++) begin
        a0 = n[4*c]; a1 = n[4*c+1]; a2 = n[4*c+2]; a3 = n[4*c+3];
        if (r < 10) begin
          s[4*c]   = gm(a0, 8'h02) ^ gm(a1, 8'h03) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ gm(a1, 8'h02) ^ gm(a2, 8'h03) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ gm(a2, 8'h02) ^ gm(a3, 8'h03);
          s[4*c+3] = gm(a0, 8'h03) ^ a1 ^ a2 ^ gm(a3, 8'h02);
        end else begin
          s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*r + i/4][31-8*(i%4) -: 8];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  // ---------------- AES core model, 10-cycle latency ----------------
  logic         cm_busy = 1'b0;
  int           cm_cnt = 0;
  logic [127:0] cm_blk = '0;

  always @(posedge clk) begin
    core_done <= 1'b0;
    if (cm_busy) begin
      if (cm_cnt == 0) begin
        core_done   <= 1'b1;
        core_result <= aes128(KEY, cm_blk);
        cm_busy     <= 1'b0;
      end else begin
        cm_cnt <= cm_cnt - 1;
      end
    end else if (core_start) begin
      cm_busy <= 1'b1;
      cm_blk  <= core_block;
      cm_cnt  <= 8;
    end
  end

  always @(negedge clk) if (core_start === 1'b1) q_core_seen.push_back(core_block);

  initial begin
    #400000;
    $display("FAIL watchdog expired: simulation did not finish");
    $fatal(1);
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_start(input logic [127:0] n, input logic [15:0] nb);
    start = 1'b1; nonce = n; num_blocks = nb;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic xfer_block(input logic [127:0] pt, input logic [127:0] ctrblk,
                            input logic last, input int bp, input string tag);
    int cnt;
    logic [127:0] got_blk, exp_ct, hold;
    logic exp_last, stable;
    cnt = 0;
    while (pt_ready !== 1'b1 && cnt < 200) begin @(negedge clk); cnt++; end
    n_total++;
    if (pt_ready !== 1'b1) $display("FAIL %s_pt_ready got %b exp 1", tag, pt_ready);
    else n_pass++;
    got_blk = 'x;
    if (q_core_seen.size() > 0) got_blk = q_core_seen.pop_front();
    n_total++;
    if (got_blk !== ctrblk) $display("FAIL %s_core_block got %h exp %h", tag, got_blk, ctrblk);
    else n_pass++;
    q_exp_ct.push_back(aes128(KEY, ctrblk) ^ pt);
    q_exp_last.push_back(last);
    pt_valid = 1'b1; pt_data = pt; ct_ready = (bp == 0);
    @(negedge clk);
    pt_valid = 1'b0; pt_data = '1;
    n_total++;
    if (ct_valid !== 1'b1) $display("FAIL %s_ct_valid_latency got %b exp 1", tag, ct_valid);
    else n_pass++;
    if (bp > 0) begin
      hold = ct_data; stable = 1'b1;
      for (int i = 0; i < bp; i++) begin
        if (ct_valid !== 1'b1 || ct_data !== hold || core_start !== 1'b0 || pt_ready !== 1'b0)
          stable = 1'b0;
        @(negedge clk);
      end
      n_total++;
      if (!stable || ct_valid !== 1'b1 || ct_data !== hold)
        $display("FAIL %s_backpressure_stable got %b exp 1", tag, stable);
      else n_pass++;
      ct_ready = 1'b1;
    end
    exp_ct = q_exp_ct.pop_front();
    exp_last = q_exp_last.pop_front();
    n_total++;
    if (ct_data !== exp_ct) $display("FAIL %s_ct_data got %h exp %h", tag, ct_data, exp_ct);
    else n_pass++;
    n_total++;
    if (ct_last !== exp_last) $display("FAIL %s_ct_last got %b exp %b", tag, ct_last, exp_last);
    else n_pass++;
    @(negedge clk);
    ct_ready = 1'b0;
    n_total++;
    if (done !== last || ct_valid !== 1'b0)
      $display("FAIL %s_done_after_hs got done=%b ct_valid=%b exp done=%b ct_valid=0",
               tag, done, ct_valid, last);
    else n_pass++;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    reset = 1'b1; start = 1'b0; abort = 1'b0; pt_valid = 1'b0; ct_ready = 1'b0;
    nonce = '0; pt_data = '0; num_blocks = '0;
    repeat (3) @(negedge clk);
    n_total++;
    if ({pt_ready, ct_valid, ct_last, core_start, busy, done, ctr_wrap, ct_data, core_block} !== '0)
      $display("FAIL reset_outputs got %b%b%b%b%b%b%b %h %h exp all zero", pt_ready, ct_valid,
               ct_last, core_start, busy, done, ctr_wrap, ct_data, core_block);
    else n_pass++;
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_sp800_vector;
    logic [127:0] n0, n1;
    n0 = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
    n1 = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdff00;
    do_start(n0, 16'd2);
    n_total++;
    if (core_start !== 1'b1 || busy !== 1'b1)
      $display("FAIL t1_start_latency got core_start=%b busy=%b exp 1 1", core_start, busy);
    else n_pass++;
    xfer_block(128'h6bc1bee22e409f96e93d7e117393172a, n0, 1'b0, 0, "t1_b0");
    n_total++;
    if (ct_data !== 128'h874d6191b620e3261bef6864990db6ce)
      $display("FAIL t1_known_ct0 got %h exp 874d6191b620e3261bef6864990db6ce", ct_data);
    else n_pass++;
    xfer_block(128'hae2d8a571e03ac9c9eb76fac45af8e51, n1, 1'b1, 0, "t1_b1");
    n_total++;
    if (ct_data !== 128'h9806f66b7970fdff8617187bb9fffdff || busy !== 1'b0)
      $display("FAIL t1_known_ct1 got %h busy=%b exp 9806f66b7970fdff8617187bb9fffdff busy=0",
               ct_data, busy);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (done !== 1'b0 || ct_data !== 128'h9806f66b7970fdff8617187bb9fffdff)
      $display("FAIL t1_done_single_pulse got done=%b ct=%h exp done=0 ct held", done, ct_data);
    else n_pass++;
  endtask

  task automatic test_ctr_wrap;
    logic [127:0] n0, n1;
    n0 = {96'h0123456789abcdef01234567, 32'hffffffff};
    n1 = {n0[127:32], 32'h00000000};
    do_start(n0, 16'd2);
    xfer_block(128'h00112233445566778899aabbccddeeff, n0, 1'b0, 0, "t2_b0");
    n_total++;
    if (ctr_wrap !== 1'b1) $display("FAIL t2_wrap_set got %b exp 1", ctr_wrap);
    else n_pass++;
    xfer_block(128'hffeeddccbbaa99887766554433221100, n1, 1'b1, 0, "t2_b1");
    repeat (5) @(negedge clk);
    n_total++;
    if (ctr_wrap !== 1'b1) $display("FAIL t2_wrap_sticky got %b exp 1", ctr_wrap);
    else n_pass++;
  endtask

  task automatic test_backpressure;
    logic [127:0] n0, n1;
    n0 = 128'h11111111222222223333333344444444;
    n1 = 128'h11111111222222223333333344444445;
    do_start(n0, 16'd2);
    n_total++;
    if (ctr_wrap !== 1'b0) $display("FAIL t3_wrap_cleared got %b exp 0", ctr_wrap);
    else n_pass++;
    xfer_block(128'hdeadbeef0badf00dcafebabe12345678, n0, 1'b0, 20, "t3_b0");
    xfer_block(128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0, n1, 1'b1, 0, "t3_b1");
  endtask

  task automatic test_zero_and_busy_start;
    logic [127:0] n0, n1;
    do_start(128'haaaa0000bbbb1111cccc2222dddd3333, 16'd0);
    n_total++;
    if (done !== 1'b1 || busy !== 1'b0 || core_start !== 1'b0)
      $display("FAIL t4_zero_done got done=%b busy=%b core_start=%b exp 1 0 0", done, busy, core_start);
    else n_pass++;
    repeat (12) @(negedge clk);
    n_total++;
    if (done !== 1'b0 || q_core_seen.size() != 0)
      $display("FAIL t4_zero_no_core got done=%b core_starts=%0d exp 0 0", done, q_core_seen.size());
    else n_pass++;
    n0 = 128'h5555555566666666777777778888888e;
    n1 = 128'h5555555566666666777777778888888f;
    do_start(n0, 16'd2);
    repeat (2) @(negedge clk);
    do_start(128'h99999999999999999999999999999999, 16'd5);
    xfer_block(128'h13579bdf2468ace013579bdf2468ace0, n0, 1'b0, 0, "t4_b0");
    xfer_block(128'hfedcba9876543210fedcba9876543210, n1, 1'b1, 0, "t4_b1");
    repeat (12) @(negedge clk);
    n_total++;
    if (q_core_seen.size() != 0 || busy !== 1'b0)
      $display("FAIL t4_busy_start_ignored got extra_core=%0d busy=%b exp 0 0", q_core_seen.size(), busy);
    else n_pass++;
  endtask

  task automatic test_abort;
    logic [127:0] prev_ct, n1;
    logic clean;
    prev_ct = ct_data;
    do_start(128'h0badc0de0badc0de0badc0de00000010, 16'd2);
    repeat (2) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    n_total++;
    if (busy !== 1'b0 || pt_ready !== 1'b0 || ct_valid !== 1'b0 || ct_last !== 1'b0 ||
        done !== 1'b0 || ct_data !== prev_ct)
      $display("FAIL t5_abort_idle got busy=%b pt_ready=%b ct_valid=%b done=%b ct=%h exp 0 0 0 0 ct=%h",
               busy, pt_ready, ct_valid, done, ct_data, prev_ct);
    else n_pass++;
    clean = 1'b1;
    for (int i = 0; i < 15; i++) begin
      if (done !== 1'b0 || busy !== 1'b0 || pt_ready !== 1'b0 || ct_valid !== 1'b0) clean = 1'b0;
      @(negedge clk);
    end
    n_total++;
    if (!clean) $display("FAIL t5_late_core_done got clean=%b exp 1", clean);
    else n_pass++;
    q_core_seen.delete();
    n1 = 128'h7777777788888888999999990000aaaa;
    do_start(n1, 16'd1);
    xfer_block(128'h3243f6a8885a308d313198a2e0370734, n1, 1'b1, 0, "t5_after");
  endtask

  task automatic test_reset_in_out;
    logic [127:0] n0, exp_ct;
    int cnt;
    n0 = 128'h0102030405060708090a0b0c0d0e0f10;
    do_start(n0, 16'd1);
    cnt = 0;
    while (pt_ready !== 1'b1 && cnt < 200) begin @(negedge clk); cnt++; end
    if (q_core_seen.size() > 0) void'(q_core_seen.pop_front());
    q_exp_ct.push_back(aes128(KEY, n0) ^ 128'h00000000111111112222222233333333);
    pt_valid = 1'b1; pt_data = 128'h00000000111111112222222233333333; ct_ready = 1'b0;
    @(negedge clk);
    pt_valid = 1'b0;
    exp_ct = q_exp_ct.pop_front();
    n_total++;
    if (ct_valid !== 1'b1 || ct_data !== exp_ct)
      $display("FAIL t6_pre_reset_ct got valid=%b ct=%h exp 1 %h", ct_valid, ct_data, exp_ct);
    else n_pass++;
    reset = 1'b1;
    @(negedge clk);
    n_total++;
    if ({pt_ready, ct_valid, ct_last, core_start, busy, done, ctr_wrap, ct_data, core_block} !== '0)
      $display("FAIL t6_reset_in_out got ct_valid=%b busy=%b ct=%h blk=%h exp all zero",
               ct_valid, busy, ct_data, core_block);
    else n_pass++;
    reset = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_sp800_vector();
    test_ctr_wrap();
    test_backpressure();
    test_zero_and_busy_start();
    test_abort();
    test_reset_in_out();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
